// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter: FSM state
// encodings, grant identifiers and the default bus-ack timeout.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Default number of busy cycles to wait for bus_ack before aborting
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    // 2-bit FSM encodings, shared with the controller
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_I_BUSY = 2'b01,
        ST_D_BUSY = 2'b10
    } arb_state_e;

    // Identifies which port won the most recent grant
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // True while a bus transaction is outstanding
    function automatic logic is_busy(input arb_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
// Combinational grant selection between the instruction and data ports.
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on a collision the port not granted last wins (needs last_i)
//   undefined : on a collision the data port always wins (no last_i port)
// Ports:
//   ireq_i   - instruction port request
//   dreq_i   - data port request
//   last_i   - port granted most recently (round-robin build only)
//   valid_o  - a grant is available this cycle (combinational)
//   pick_d_o - 1 = grant data port, 0 = grant instruction port (combinational)
// ---------------------------------------------------------------------------
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   ireq_i,
    input  logic   dreq_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  grant_e last_i,
`endif
    output logic   valid_o,
    output logic   pick_d_o
);

    // Single requester wins outright; collisions resolved per build option
    always_comb begin
        valid_o  = ireq_i || dreq_i;
        pick_d_o = dreqi_sel();
    end

    function automatic logic dreqi_sel();
`ifdef ARB_ROUND_ROBIN_EN
        if (ireq_i && dreq_i) begin
            return last_i == GNT_I;
        end
        return dreq_i;
`else
        return dreq_i;
`endif
    endfunction

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction (read-only) port and a data (read/write) port
// onto a single Wishbone-style memory bus, one transaction at a time, with a
// bus-ack timeout that aborts the access and raises a sticky error flag.
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin vs. data-priority
// collision resolution, see arb_pick).
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   i_req/i_addr                - instruction request and address
//   i_rdata/i_stall             - instruction read data and stall
//   d_req/d_we/d_addr/d_wdata   - data request, write enable, address, data
//   d_rdata/d_stall             - data read data and stall
//   bus_cyc/bus_stb/bus_we      - bus cycle, strobe, write enable
//   bus_addr/bus_wdata          - bus address and write data
//   bus_rdata/bus_ack           - bus read data and acknowledge
//   bus_err                     - sticky timeout flag, cleared by rst only
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              bus_cyc,
    output logic              bus_stb,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] i_hold_q;
    logic [DATA_W-1:0] d_hold_q;
    logic              err_q;

    logic pick_valid_c;
    logic pick_d_c;
    logic i_busy_c;
    logic d_busy_c;
    logic timeout_c;
    logic done_c;
    logic i_take_c;
    logic d_take_c;

`ifdef ARB_ROUND_ROBIN_EN
    grant_e last_q;

    arb_pick u_arb_pick (
        .ireq_i   (i_req),
        .dreq_i   (d_req),
        .last_i   (last_q),
        .valid_o  (pick_valid_c),
        .pick_d_o (pick_d_c)
    );
`else
    arb_pick u_arb_pick (
        .ireq_i   (i_req),
        .dreq_i   (d_req),
        .valid_o  (pick_valid_c),
        .pick_d_o (pick_d_c)
    );
`endif

    // Transaction status decode
    assign i_busy_c  = (state_q == ST_I_BUSY);
    assign d_busy_c  = (state_q == ST_D_BUSY);
    assign timeout_c = is_busy(state_q) && !bus_ack && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done_c    = is_busy(state_q) && (bus_ack || timeout_c);
    assign cnt_d     = cnt_q + CNT_W'(1);

    // Read data is delivered only to a requester still waiting; writes never update d_rdata
    assign i_take_c = i_busy_c && bus_ack && i_req;
    assign d_take_c = d_busy_c && bus_ack && d_req && !we_q;

    // Stall drops in the ack (or timeout) cycle of the owning port
    assign i_stall = i_req && !(i_busy_c && (bus_ack || timeout_c));
    assign d_stall = d_req && !(d_busy_c && (bus_ack || timeout_c));

    // Read data: live bus data on ack, zero on timeout abort, else last captured value
    always_comb begin
        i_rdata = i_hold_q;
        d_rdata = d_hold_q;
        if (i_take_c) begin
            i_rdata = bus_rdata;
        end else if (i_busy_c && timeout_c) begin
            i_rdata = '0;
        end
        if (d_take_c) begin
            d_rdata = bus_rdata;
        end else if (d_busy_c && timeout_c) begin
            d_rdata = '0;
        end
    end

    // Bus outputs come straight from registers that are cleared whenever idle
    assign bus_cyc   = is_busy(state_q);
    assign bus_stb   = is_busy(state_q);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_err   = err_q;

    // Arbiter FSM with latched request and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            i_hold_q <= '0;
            d_hold_q <= '0;
            err_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q   <= GNT_I;
`endif
        end else begin
            if (i_take_c) begin
                i_hold_q <= bus_rdata;
            end
            if (d_take_c) begin
                d_hold_q <= bus_rdata;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (pick_valid_c) begin
                        cnt_q <= '0;
                        if (pick_d_c) begin
                            state_q <= ST_D_BUSY;
                            addr_q  <= d_addr;
                            we_q    <= d_we;
                            wdata_q <= d_wdata;
`ifdef ARB_ROUND_ROBIN_EN
                            last_q  <= GNT_D;
`endif
                        end else begin
                            state_q <= ST_I_BUSY;
                            addr_q  <= i_addr;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                            last_q  <= GNT_I;
`endif
                        end
                    end
                end
                ST_I_BUSY, ST_D_BUSY: begin
                    if (done_c) begin
                        state_q <= ST_IDLE;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        if (timeout_c) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    addr_q  <= '0;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int unsigned TO = 15;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_stall   (i_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_stall   (d_stall),
        .bus_cyc   (bus_cyc),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    // ctl = {rst, i_req, d_req, d_we, bus_ack}; ex = {i_stall, d_stall, bus_cyc, bus_we, bus_err}
    typedef struct {
        logic [4:0]  ctl;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] rdata;
        logic [4:0]  ex;
        logic [31:0] e_irdata;
        logic [31:0] e_drdata;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [20];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] dw, input logic [31:0] rd);
        rst       = ctl[4];
        i_req     = ctl[3];
        d_req     = ctl[2];
        d_we      = ctl[1];
        bus_ack   = ctl[0];
        i_addr    = ia;
        d_addr    = da;
        d_wdata   = dw;
        bus_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_d;

        tbl[0]  = '{5'b10000, 32'h0,   32'h0,  32'h0,  32'h0,        5'b00000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[1]  = '{5'b01000, 32'h100, 32'h0,  32'h0,  32'h0,        5'b10000, 32'h0,        32'h0,        32'h0,   32'h0};
        tbl[2]  = '{5'b01001, 32'h100, 32'h0,  32'h0,  32'hDEADBEEF, 5'b00100, 32'hDEADBEEF, 32'h0,        32'h100, 32'h0};
        tbl[3]  = '{5'b00000, 32'h0,   32'h0,  32'h0,  32'h12345678, 5'b00000, 32'hDEADBEEF, 32'h0,        32'h0,   32'h0};
        tbl[4]  = '{5'b00110, 32'h0,   32'h20, 32'h55, 32'h0,        5'b01000, 32'hDEADBEEF, 32'h0,        32'h0,   32'h0};
        tbl[5]  = '{5'b00110, 32'h0,   32'h20, 32'h55, 32'h0,        5'b01110, 32'hDEADBEEF, 32'h0,        32'h20,  32'h55};
        tbl[6]  = '{5'b00111, 32'h0,   32'h20, 32'h55, 32'hAAAA5555, 5'b00110, 32'hDEADBEEF, 32'h0,        32'h20,  32'h55};
        tbl[7]  = '{5'b00000, 32'h0,   32'h0,  32'h0,  32'h0,        5'b00000, 32'hDEADBEEF, 32'h0,        32'h0,   32'h0};
        tbl[8]  = '{5'b00100, 32'h0,   32'h44, 32'h0,  32'h0,        5'b01000, 32'hDEADBEEF, 32'h0,        32'h0,   32'h0};
        tbl[9]  = '{5'b00101, 32'h0,   32'h44, 32'h0,  32'hCAFEF00D, 5'b00100, 32'hDEADBEEF, 32'hCAFEF00D, 32'h44,  32'h0};
        tbl[10] = '{5'b00001, 32'h0,   32'h0,  32'h0,  32'h11111111, 5'b00000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,   32'h0};
        tbl[11] = '{5'b01000, 32'h200, 32'h0,  32'h0,  32'h0,        5'b10000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,   32'h0};
        tbl[12] = '{5'b00000, 32'h0,   32'h0,  32'h0,  32'h0,        5'b00100, 32'hDEADBEEF, 32'hCAFEF00D, 32'h200, 32'h0};
        tbl[13] = '{5'b00001, 32'h0,   32'h0,  32'h0,  32'h99999999, 5'b00100, 32'hDEADBEEF, 32'hCAFEF00D, 32'h200, 32'h0};
        tbl[14] = '{5'b00000, 32'h0,   32'h0,  32'h0,  32'h0,        5'b00000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,   32'h0};
        tbl[15] = '{5'b01000, 32'h300, 32'h0,  32'h0,  32'h0,        5'b10000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0,   32'h0};
        tbl[16] = '{5'b01001, 32'h300, 32'h0,  32'h0,  32'h3,        5'b00100, 32'h3,        32'hCAFEF00D, 32'h300, 32'h0};
        tbl[17] = '{5'b01000, 32'h304, 32'h0,  32'h0,  32'h0,        5'b10000, 32'h3,        32'hCAFEF00D, 32'h0,   32'h0};
        tbl[18] = '{5'b01001, 32'h304, 32'h0,  32'h0,  32'h4,        5'b00100, 32'h4,        32'hCAFEF00D, 32'h304, 32'h0};
        tbl[19] = '{5'b00000, 32'h0,   32'h0,  32'h0,  32'h0,        5'b00000, 32'h4,        32'hCAFEF00D, 32'h0,   32'h0};

        drive(5'b10000, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;

        // Single-port transactions, one table row per clock cycle
        for (int r = 0; r < 20; r++) begin
            drive(tbl[r].ctl, tbl[r].iaddr, tbl[r].daddr, tbl[r].dwdata, tbl[r].rdata);
            @(negedge clk);
            chk1 ($sformatf("row%0d.i_stall", r),   i_stall,   tbl[r].ex[4]);
            chk1 ($sformatf("row%0d.d_stall", r),   d_stall,   tbl[r].ex[3]);
            chk1 ($sformatf("row%0d.bus_cyc", r),   bus_cyc,   tbl[r].ex[2]);
            chk1 ($sformatf("row%0d.bus_stb", r),   bus_stb,   tbl[r].ex[2]);
            chk1 ($sformatf("row%0d.bus_we", r),    bus_we,    tbl[r].ex[1]);
            chk1 ($sformatf("row%0d.bus_err", r),   bus_err,   tbl[r].ex[0]);
            chk32($sformatf("row%0d.i_rdata", r),   i_rdata,   tbl[r].e_irdata);
            chk32($sformatf("row%0d.d_rdata", r),   d_rdata,   tbl[r].e_drdata);
            chk32($sformatf("row%0d.bus_addr", r),  bus_addr,  tbl[r].e_addr);
            chk32($sformatf("row%0d.bus_wdata", r), bus_wdata, tbl[r].e_wdata);
            tick();
        end

        // Collisions starting from reset (last grant = instruction)
        drive(5'b10000, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(5'b01100, 32'hA00, 32'hB00, 32'h0, 32'h0);
            @(negedge clk);
            chk1($sformatf("coll%0d.idle_i_stall", k), i_stall, 1'b1);
            chk1($sformatf("coll%0d.idle_d_stall", k), d_stall, 1'b1);
            chk1($sformatf("coll%0d.idle_cyc", k),     bus_cyc, 1'b0);
            tick();
            exp_d = RR ? (k != 1) : 1'b1;
            drive(5'b01101, 32'hA00, 32'hB00, 32'h0, 32'(32'h10 + k));
            @(negedge clk);
            chk32($sformatf("coll%0d.bus_addr", k), bus_addr, exp_d ? 32'hB00 : 32'hA00);
            chk1 ($sformatf("coll%0d.i_stall", k),  i_stall, exp_d);
            chk1 ($sformatf("coll%0d.d_stall", k),  d_stall, !exp_d);
            chk32($sformatf("coll%0d.rdata", k),    exp_d ? d_rdata : i_rdata, 32'(32'h10 + k));
            tick();
        end

        // Timeout: prime d_rdata, then a read that is never acknowledged
        drive(5'b00100, 32'h0, 32'h60, 32'h0, 32'h0);
        @(negedge clk);
        chk1("to.prime_grant_stall", d_stall, 1'b1);
        tick();
        drive(5'b00101, 32'h0, 32'h60, 32'h0, 32'h5A5A5A5A);
        @(negedge clk);
        chk32("to.prime_rdata", d_rdata, 32'h5A5A5A5A);
        tick();
        drive(5'b00100, 32'h0, 32'h64, 32'h0, 32'h0);
        @(negedge clk);
        chk1("to.grant_stall", d_stall, 1'b1);
        tick();
        for (int k = 1; k <= int'(TO); k++) begin
            drive(5'b00100, 32'h0, 32'h64, 32'h0, 32'hFFFF0000);
            @(negedge clk);
            if (k < int'(TO)) begin
                chk1 ($sformatf("to.busy%0d.d_stall", k), d_stall, 1'b1);
                chk32($sformatf("to.busy%0d.d_rdata", k), d_rdata, 32'h5A5A5A5A);
            end else begin
                chk1 ("to.release.d_stall", d_stall, 1'b0);
                chk32("to.release.d_rdata", d_rdata, 32'h0);
            end
            chk1($sformatf("to.busy%0d.cyc", k), bus_cyc, 1'b1);
            chk1($sformatf("to.busy%0d.err", k), bus_err, 1'b0);
            tick();
        end
        drive(5'b00000, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk1 ("to.after.cyc", bus_cyc, 1'b0);
        chk1 ("to.after.err", bus_err, 1'b1);
        chk32("to.after.d_rdata", d_rdata, 32'h5A5A5A5A);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("to.sticky%0d.err", k), bus_err, 1'b1);
            tick();
        end

        // Reset asserted during a data write
        drive(5'b00110, 32'h0, 32'h80, 32'h77, 32'h0);
        @(negedge clk);
        chk1("rst.grant_stall", d_stall, 1'b1);
        tick();
        drive(5'b10110, 32'h0, 32'h80, 32'h77, 32'h0);
        @(negedge clk);
        chk1 ("rst.busy.cyc", bus_cyc, 1'b1);
        chk32("rst.busy.addr", bus_addr, 32'h80);
        chk1 ("rst.busy.err", bus_err, 1'b1);
        tick();
        drive(5'b11100, 32'h90, 32'h80, 32'h77, 32'h0);
        @(negedge clk);
        chk1 ("rst.after.cyc", bus_cyc, 1'b0);
        chk1 ("rst.after.we", bus_we, 1'b0);
        chk32("rst.after.addr", bus_addr, 32'h0);
        chk1 ("rst.after.i_stall", i_stall, 1'b1);
        chk1 ("rst.after.d_stall", d_stall, 1'b1);
        chk1 ("rst.after.err", bus_err, 1'b0);
        tick();
        drive(5'b10000, 32'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk1("rst.noreq.i_stall", i_stall, 1'b0);
        chk1("rst.noreq.d_stall", d_stall, 1'b0);
        chk1("rst.noreq.cyc", bus_cyc, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
